// File: rtl/ysyx_25020047_lsu_ctrl_pkg.sv
// Shared types and codes for the load/store controller: FSM states,
// funct3 width encodings and completion fault codes.
package ysyx_25020047_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_BUSERR   = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

endpackage

// File: rtl/ysyx_25020047_lsu_ctrl_if.sv
// Data-memory port between the LSU (master) and the memory (slave):
// valid/ready request channel plus a response/ack channel.
interface ysyx_25020047_lsu_ctrl_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        mem_resp_err;

    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
    );
endinterface

// File: rtl/ysyx_25020047_lsu_ctrl_align.sv
// Combinational lane logic: store data/strobe placement and legality check on
// the incoming request, load byte/half extraction and extension on the response.
module ysyx_25020047_lsu_align
    import ysyx_25020047_lsu_pkg::*;
(
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_off,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    output logic        illegal,
    input  logic [2:0]  rsp_funct3,
    input  logic [1:0]  rsp_off,
    input  logic [31:0] rsp_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shift;

    always_comb begin
        st_wdata = req_wdata;
        st_wstrb = 4'b1111;
        illegal  = 1'b0;
        case (req_funct3)
            F3_B: begin
                st_wdata = {24'b0, req_wdata[7:0]} << {req_off, 3'b000};
                st_wstrb = 4'b0001 << req_off;
            end
            F3_H: begin
                st_wdata = {16'b0, req_wdata[15:0]} << {req_off, 3'b000};
                st_wstrb = 4'b0011 << req_off;
                illegal  = req_off[0];
            end
            F3_W:    illegal = (req_off != 2'b00);
            // Unsigned widths only exist for loads
            F3_BU:   illegal = req_write;
            F3_HU:   illegal = req_write | req_off[0];
            default: illegal = 1'b1;
        endcase
    end

    assign ld_shift = rsp_rdata >> {rsp_off, 3'b000};

    always_comb begin
        case (rsp_funct3)
            F3_B:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            F3_H:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            F3_BU:   ld_data = {24'b0, ld_shift[7:0]};
            F3_HU:   ld_data = {16'b0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

endmodule

// File: rtl/ysyx_25020047_lsu_ctrl.sv
// Multi-cycle load/store controller: accepts one EXU memory op, runs the
// valid/ready request and response handshake, and reports data or a fault.
module ysyx_25020047_lsu_ctrl
    import ysyx_25020047_lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_read,
    input  logic        ex_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        ex_ready,
    output logic        busy,
    ysyx_25020047_lsu_ctrl_if.master mem,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_fault
);

    localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

    lsu_state_e  state_q, state_d;
    logic [9:0]  cnt_q, cnt_d, cnt_inc;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic        req_valid_q, req_valid_d;
    logic        done_q, done_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  fault_q, fault_d;

    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic        illegal;
    logic [31:0] ld_data;
    logic        timeout_hit;

    ysyx_25020047_lsu_align u_align (
        .req_funct3 (ex_funct3),
        .req_off    (ex_addr[1:0]),
        .req_write  (ex_write),
        .req_wdata  (ex_wdata),
        .st_wdata   (st_wdata),
        .st_wstrb   (st_wstrb),
        .illegal    (illegal),
        .rsp_funct3 (funct3_q),
        .rsp_off    (off_q),
        .rsp_rdata  (mem.mem_rdata),
        .ld_data    (ld_data)
    );

    assign cnt_inc     = cnt_q + 10'd1;
    assign timeout_hit = (cnt_inc == TIMEOUT_CNT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        req_valid_d = req_valid_q;
        done_d      = 1'b0;
        rdata_d     = rdata_q;
        fault_d     = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid && (ex_read || ex_write)) begin
                    cnt_d    = '0;
                    addr_d   = {ex_addr[31:2], 2'b00};
                    we_d     = ex_write;
                    wdata_d  = st_wdata;
                    wstrb_d  = ex_write ? st_wstrb : 4'b0000;
                    funct3_d = ex_funct3;
                    off_d    = ex_addr[1:0];
                    // Bad requests complete immediately without touching the bus
                    if ((ex_read && ex_write) || illegal) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        fault_d = FAULT_MISALIGN;
                        rdata_d = '0;
                    end else begin
                        state_d     = ST_REQ;
                        req_valid_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_inc;
                if (timeout_hit) begin
                    state_d     = ST_DONE;
                    req_valid_d = 1'b0;
                    done_d      = 1'b1;
                    fault_d     = FAULT_TIMEOUT;
                    rdata_d     = '0;
                end else if (mem.mem_req_ready) begin
                    state_d     = ST_WAIT;
                    req_valid_d = 1'b0;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                if (mem.mem_resp_valid) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    fault_d = mem.mem_resp_err ? FAULT_BUSERR : FAULT_OK;
                    rdata_d = (we_q || mem.mem_resp_err) ? 32'd0 : ld_data;
                end else if (timeout_hit) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    fault_d = FAULT_TIMEOUT;
                    rdata_d = '0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            req_valid_q <= 1'b0;
            done_q      <= 1'b0;
            rdata_q     <= '0;
            fault_q     <= FAULT_OK;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            req_valid_q <= req_valid_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
        end
    end

    assign ex_ready          = (state_q == ST_IDLE) & ~rst;
    assign busy              = (state_q != ST_IDLE);
    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_we        = we_q;
    assign mem.mem_addr      = addr_q;
    assign mem.mem_wdata     = wdata_q;
    assign mem.mem_wstrb     = wstrb_q;
    assign lsu_done          = done_q;
    assign lsu_rdata         = rdata_q;
    assign lsu_fault         = fault_q;

endmodule

// File: tb/tb_ysyx_25020047_lsu_ctrl.sv
// Directed bench for the LSU controller: a transaction-level model predicts
// per-op results and cycle timing; one process compares the DUT every cycle.
module tb_ysyx_25020047_lsu_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_read = 1'b0;
    logic        ex_write = 1'b0;
    logic [2:0]  ex_funct3 = 3'b000;
    logic [31:0] ex_addr = 32'd0;
    logic [31:0] ex_wdata = 32'd0;
    logic        ex_ready;
    logic        busy;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_fault;

    ysyx_25020047_lsu_ctrl_if mem_bus ();

    ysyx_25020047_lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_valid  (ex_valid),
        .ex_read   (ex_read),
        .ex_write  (ex_write),
        .ex_funct3 (ex_funct3),
        .ex_addr   (ex_addr),
        .ex_wdata  (ex_wdata),
        .ex_ready  (ex_ready),
        .busy      (busy),
        .mem       (mem_bus),
        .lsu_done  (lsu_done),
        .lsu_rdata (lsu_rdata),
        .lsu_fault (lsu_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int          cur_cyc = 0;
    bit          op_active = 1'b0;
    logic [1:0]  exp_fault = 2'b00, prev_fault = 2'b00;
    logic [31:0] exp_rdata = 32'd0, prev_rdata = 32'd0;
    logic [31:0] exp_addr = 32'd0, exp_wdata = 32'd0;
    logic [3:0]  exp_wstrb = 4'd0;
    logic        exp_we = 1'b0;
    int          exp_done_cyc = -1;
    int          exp_req_last = 0;

    bit          cap_req_seen;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;
    int          cap_done_cyc;

    logic        exp_busy, exp_req;

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h t=%0t", nm, act, req, $time);
        end
    endtask

    // Transaction-level model: what the op must produce and when, from the
    // access rules and the memory-side timing chosen for it.
    task automatic modelOp(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdat, input logic err,
                           input int ready_dly, input int resp_dly, input bit respond);
        int size, off, h, r;
        logic [31:0] mask, sh, v;
        bit bad;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off  = int'(addr % 4);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        bad  = (rd && wr) || (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
               (wr && f3[2]) || ((addr % size) != 0);
        exp_addr  = addr & 32'hFFFF_FFFC;
        exp_we    = wr;
        exp_wdata = (wd & mask) << (8 * off);
        exp_wstrb = wr ? 4'(((1 << size) - 1) << off) : 4'b0000;
        sh = rdat >> (8 * off);
        v  = sh & mask;
        if (size < 4 && !f3[2] && v[8 * size - 1]) v = v | ~mask;
        h = 1 + ready_dly;
        r = h + 1 + resp_dly;
        if (!(rd || wr)) begin
            exp_done_cyc = -1; exp_req_last = 0;
            exp_fault = prev_fault; exp_rdata = prev_rdata;
        end else if (bad) begin
            exp_done_cyc = 1; exp_req_last = 0;
            exp_fault = 2'b01; exp_rdata = 32'd0;
        end else if (h >= TO) begin
            exp_done_cyc = TO + 1; exp_req_last = TO;
            exp_fault = 2'b11; exp_rdata = 32'd0;
        end else if (respond && r <= TO) begin
            exp_done_cyc = r + 1; exp_req_last = h;
            exp_fault = err ? 2'b10 : 2'b00;
            exp_rdata = (wr || err) ? 32'd0 : v;
        end else begin
            exp_done_cyc = TO + 1; exp_req_last = h;
            exp_fault = 2'b11; exp_rdata = 32'd0;
        end
    endtask

    // Per-cycle comparison against the model while an op is in progress
    always begin
        @(negedge clk);
        #1;
        if (op_active) begin
            exp_busy = (cur_cyc >= 1) && (cur_cyc <= exp_done_cyc);
            exp_req  = (cur_cyc >= 1) && (cur_cyc <= exp_req_last);
            checkOutput("busy", 32'(busy), 32'(exp_busy));
            checkOutput("ex_ready", 32'(ex_ready), 32'(!exp_busy));
            checkOutput("lsu_done", 32'(lsu_done), 32'(cur_cyc == exp_done_cyc));
            checkOutput("mem_req_valid", 32'(mem_bus.mem_req_valid), 32'(exp_req));
            if (exp_req) begin
                checkOutput("mem_addr", mem_bus.mem_addr, exp_addr);
                checkOutput("mem_we", 32'(mem_bus.mem_we), 32'(exp_we));
                checkOutput("mem_wdata", mem_bus.mem_wdata, exp_wdata);
                checkOutput("mem_wstrb", 32'(mem_bus.mem_wstrb), 32'(exp_wstrb));
            end
            if (cur_cyc >= exp_done_cyc) begin
                checkOutput("lsu_fault", 32'(lsu_fault), 32'(exp_fault));
                checkOutput("lsu_rdata", lsu_rdata, exp_rdata);
            end else begin
                checkOutput("lsu_fault_hold", 32'(lsu_fault), 32'(prev_fault));
                checkOutput("lsu_rdata_hold", lsu_rdata, prev_rdata);
            end
        end
    end

    // One op: accept in cycle 0, then play the memory side cycle by cycle.
    // stray_cyc injects an extra response pulse; rst_cyc resets mid-op.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rdat, input logic err,
                                 input int ready_dly, input int resp_dly, input bit respond,
                                 input int stray_cyc, input int rst_cyc);
        int h, r, last;
        bit was_reset;
        modelOp(rd, wr, f3, addr, wd, rdat, err, ready_dly, resp_dly, respond);
        h = 1 + ready_dly;
        r = h + 1 + resp_dly;
        last = ((exp_done_cyc > stray_cyc) ? exp_done_cyc : stray_cyc) + 2;
        cap_req_seen = 1'b0;
        cap_done_cyc = -1;
        was_reset = 1'b0;
        @(negedge clk);
        cur_cyc = 0;
        op_active = 1'b1;
        ex_valid = 1'b1; ex_read = rd; ex_write = wr;
        ex_funct3 = f3; ex_addr = addr; ex_wdata = wd;
        mem_bus.mem_rdata = rdat;
        mem_bus.mem_resp_err = err;
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_resp_valid = 1'b0;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            ex_valid = 1'b0; ex_read = 1'b0; ex_write = 1'b0;
            if (c == rst_cyc) begin
                op_active = 1'b0;
                was_reset = 1'b1;
                mem_bus.mem_req_ready = 1'b0;
                mem_bus.mem_resp_valid = 1'b0;
                rst = 1'b1;
                #1;
                checkOutput("rst_req_valid", 32'(mem_bus.mem_req_valid), 32'd0);
                checkOutput("rst_busy", 32'(busy), 32'd0);
                checkOutput("rst_ex_ready", 32'(ex_ready), 32'd0);
                checkOutput("rst_done", 32'(lsu_done), 32'd0);
                @(negedge clk);
                #1;
                checkOutput("rst_done_hold", 32'(lsu_done), 32'd0);
                rst = 1'b0;
                @(negedge clk);
                #1;
                checkOutput("rst_ex_ready_after", 32'(ex_ready), 32'd1);
                checkOutput("rst_done_after", 32'(lsu_done), 32'd0);
                checkOutput("rst_fault_clear", 32'(lsu_fault), 32'd0);
                break;
            end
            cur_cyc = c;
            mem_bus.mem_req_ready = (c >= h);
            mem_bus.mem_resp_valid = (respond && c == r) || (c == stray_cyc);
            #2;
            if (mem_bus.mem_req_valid && !cap_req_seen) begin
                cap_req_seen = 1'b1;
                cap_addr = mem_bus.mem_addr;
                cap_wdata = mem_bus.mem_wdata;
                cap_wstrb = mem_bus.mem_wstrb;
            end
            if (lsu_done) cap_done_cyc = c;
        end
        op_active = 1'b0;
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_resp_valid = 1'b0;
        if (was_reset) begin
            prev_fault = 2'b00; prev_rdata = 32'd0;
        end else begin
            prev_fault = exp_fault; prev_rdata = exp_rdata;
        end
    endtask

    initial begin
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_rdata = 32'd0;
        mem_bus.mem_resp_err = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_ex_ready", 32'(ex_ready), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_req_valid", 32'(mem_bus.mem_req_valid), 32'd0);
        checkOutput("reset_done", 32'(lsu_done), 32'd0);
        checkOutput("reset_rdata", lsu_rdata, 32'd0);
        checkOutput("reset_fault", 32'(lsu_fault), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("reset_release_ready", 32'(ex_ready), 32'd1);

        // sb at byte 3, minimum latency
        applyStimulus(1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h1234_56AB, 32'hDEAD_BEEF, 1'b0, 0, 0, 1'b1, 0, 0);
        checkOutput("sb_addr_lit", cap_addr, 32'h8000_0000);
        checkOutput("sb_wstrb_lit", 32'(cap_wstrb), 32'h8);
        checkOutput("sb_wdata_lit", cap_wdata, 32'hAB00_0000);
        checkOutput("sb_done_cyc_lit", 32'(cap_done_cyc), 32'd3);
        checkOutput("sb_rdata_lit", lsu_rdata, 32'd0);

        applyStimulus(1'b1, 1'b0, 3'b000, 32'h8000_0001, 32'd0, 32'h0000_8000, 1'b0, 0, 0, 1'b1, 0, 0);
        checkOutput("lb_lit", lsu_rdata, 32'hFFFF_FF80);
        applyStimulus(1'b1, 1'b0, 3'b100, 32'h8000_0001, 32'd0, 32'h0000_8000, 1'b0, 0, 0, 1'b1, 0, 0);
        checkOutput("lbu_lit", lsu_rdata, 32'h0000_0080);
        applyStimulus(1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'd0, 32'hBEEF_0000, 1'b0, 0, 0, 1'b1, 0, 0);
        checkOutput("lhu_lit", lsu_rdata, 32'h0000_BEEF);
        applyStimulus(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'd0, 32'h8001_0000, 1'b0, 0, 1, 1'b1, 0, 0);
        checkOutput("lh_lit", lsu_rdata, 32'hFFFF_8001);

        applyStimulus(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'hCAFE_F00D, 32'd0, 1'b0, 1, 0, 1'b1, 0, 0);
        checkOutput("sh_wdata_lit", cap_wdata, 32'hF00D_0000);
        checkOutput("sh_wstrb_lit", 32'(cap_wstrb), 32'hC);
        applyStimulus(1'b0, 1'b1, 3'b010, 32'h8000_0008, 32'h1122_3344, 32'd0, 1'b0, 0, 2, 1'b1, 0, 0);

        // Misaligned word and read+write both set: done in cycle 1, no request
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'd0, 32'hFFFF_FFFF, 1'b0, 0, 0, 1'b1, 0, 0);
        checkOutput("lw_mis_done_cyc", 32'(cap_done_cyc), 32'd1);
        checkOutput("lw_mis_fault", 32'(lsu_fault), 32'd1);
        checkOutput("lw_mis_noreq", 32'(cap_req_seen), 32'd0);
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1'b0, 0, 0, 1'b1, 0, 0);
        checkOutput("rw_done_cyc", 32'(cap_done_cyc), 32'd1);
        checkOutput("rw_noreq", 32'(cap_req_seen), 32'd0);
        applyStimulus(1'b0, 1'b1, 3'b100, 32'h8000_0000, 32'h55, 32'd0, 1'b0, 0, 0, 1'b1, 0, 0);
        applyStimulus(1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'd0, 32'd0, 1'b0, 0, 0, 1'b1, 0, 0);
        applyStimulus(1'b1, 1'b0, 3'b101, 32'h8000_0003, 32'd0, 32'd0, 1'b0, 0, 0, 1'b1, 0, 0);

        // Back-pressure then bus error
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h8000_000C, 32'd0, 32'h1357_9BDF, 1'b1, 3, 0, 1'b1, 0, 0);
        checkOutput("buserr_fault", 32'(lsu_fault), 32'd2);
        checkOutput("buserr_done_cyc", 32'(cap_done_cyc), 32'd6);

        // Response coinciding with the handshake must not be taken
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'd0, 32'hA5A5_0F0F, 1'b0, 1, 1, 1'b1, 2, 0);
        checkOutput("early_resp_done_cyc", 32'(cap_done_cyc), 32'd5);

        // Timeout with a late response, then a normal load
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'd0, 32'h7777_7777, 1'b0, 0, 0, 1'b0, 11, 0);
        checkOutput("timeout_fault", 32'(lsu_fault), 32'd3);
        checkOutput("timeout_done_cyc", 32'(cap_done_cyc), 32'd9);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h8000_0014, 32'd0, 32'h55AA_1234, 1'b0, 0, 0, 1'b1, 0, 0);
        checkOutput("after_to_lw", lsu_rdata, 32'h55AA_1234);

        // Response in the last counted cycle beats the timeout
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h8000_0018, 32'd0, 32'h0BAD_F00D, 1'b0, 0, 6, 1'b1, 0, 0);
        checkOutput("resp_beats_to", 32'(lsu_fault), 32'd0);

        // ex_valid without direction is ignored
        applyStimulus(1'b0, 1'b0, 3'b010, 32'h8000_0000, 32'd0, 32'd0, 1'b0, 0, 0, 1'b1, 0, 0);

        // Reset while waiting for the response
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'd0, 32'd0, 1'b0, 0, 0, 1'b0, 0, 2);
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h8000_0022, 32'd0, 32'h0042_0000, 1'b0, 0, 0, 1'b1, 0, 0);
        checkOutput("after_rst_lb", lsu_rdata, 32'h0000_0042);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ysyx_25020047_lsu_ctrl.md
# ysyx_25020047_lsu_ctrl

Multi-cycle load/store controller that sits between the execute stage and the data-memory port. It accepts one memory operation at a time, using the address, read/write flags and access width produced by the EXU. It drives a valid/ready request channel and waits for the memory response. Completion is signalled to the core with aligned, extended load data or a fault code, and the core stalls on `busy`.

## Interface
Parameters:
- TIMEOUT, 255: cycles allowed in REQ+WAIT before aborting with a timeout fault (range 1..1023).

Ports (the clock is `clk`; the reset is `rst`, asynchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- ex_valid  in  1  execute-stage operation valid
- ex_read  in  1  load request (EXU `read`)
- ex_write  in  1  store request (EXU `write`)
- ex_funct3  in  3  width/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- ex_addr  in  32  effective address (EXU `result`)
- ex_wdata  in  32  store data (rs2)
- ex_ready  out  1  controller idle and able to accept
- busy  out  1  operation in flight; the core stalls PC update
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, bits [1:0] = 00
- mem_wdata  out  32  lane-shifted store data
- mem_wstrb  out  4  byte strobes (0000 on reads)
- mem_resp_valid  in  1  response/ack valid
- mem_rdata  in  32  read word
- mem_resp_err  in  1  bus error, qualified by mem_resp_valid
- lsu_done  out  1  one-cycle completion pulse
- lsu_rdata  out  32  extended load result, valid with lsu_done
- lsu_fault  out  2  00 ok, 01 misaligned/illegal, 10 bus error, 11 timeout; valid with lsu_done

## Operation
- **States:** IDLE, REQ, WAIT, DONE.
- **Accept:** the controller accepts when in IDLE, `ex_valid=1` and exactly one of read/write is set. On accept it latches addr, wdata, funct3 and direction.
- **Ignored requests:** `ex_valid` with neither read nor write is ignored, with no done pulse.
- **Read and write both set:** goes IDLE→DONE with fault 01 and issues no memory request.
- **Misaligned or illegal accesses:** the following go IDLE→DONE with fault 01 and no memory request:
  - half access with addr[0]=1;
  - word access with addr[1:0]≠00;
  - funct3 011/110/111;
  - store with funct3 100/101.
- **IDLE→REQ:** on a legal accept.
- **REQ→WAIT:** on `mem_req_valid & mem_req_ready`.
- **WAIT→DONE:** on `mem_resp_valid`. The fault is 10 if `mem_resp_err`, otherwise 00.
- **DONE→IDLE:** unconditionally.
- **Timeout:** a counter clears on accept and increments each cycle in REQ or WAIT. When it reaches TIMEOUT, the controller goes to DONE with fault 11.
- **Store lanes:** off = addr[1:0].
  - b: wdata[7:0]<<8·off, strb 0001<<off.
  - h: wdata[15:0]<<8·off, strb 0011<<off.
  - w: wdata as-is, strb 1111.
- **Load extraction:** shift = mem_rdata>>8·off, then take the low byte or half. Sign-extend for b/h; zero-extend for bu/hu.
- **lsu_rdata:** registered; it is 0 for stores and for any fault.
- **Output hold:** lsu_rdata and lsu_fault hold until the next DONE.

## Timing
- **Reset values:** state IDLE, mem_req_valid 0, lsu_done 0, lsu_rdata 0, lsu_fault 00, counter 0. ex_ready is forced 0 while rst=1.
- **Decoded outputs:** ex_ready = (state==IDLE) & ~rst; busy = (state!=IDLE).
- **mem_req_valid:** asserted exactly in REQ.
- **Request stability:** mem_addr, mem_we, mem_wdata and mem_wstrb come from registers and are stable from entering REQ until the handshake.
- **Response sampling:** `mem_resp_valid` is sampled only in WAIT. A response in the same cycle as the request handshake is not taken. Responses in IDLE, REQ or DONE are ignored, including late responses after a timeout.
- **Minimum latency:** accept at cycle 0, REQ at 1 with ready=1, response at 2, lsu_done at 3.
- **Fault latency:** the misaligned/illegal path pulses lsu_done in cycle 1.
- **Timeout vs response:** if the timeout and a response occur in the same cycle, the response wins.
- **Reset mid-operation:** reset forces IDLE immediately, drops mem_req_valid, and emits no lsu_done.

## Structure
- **Package `ysyx_25020047_lsu_pkg`:** holds the state enum, the funct3 width codes (B, H, W, BU, HU) and the fault codes (OK, MISALIGN, BUSERR, TIMEOUT).
- **Sub-module `ysyx_25020047_lsu_align`:** purely combinational. It computes the store wdata shift and strobe generation, load extraction/extension, and the misalignment/illegal check, and is shared by the request and response paths.
- **`ysyx_25020047_lsu_ctrl`:** holds the FSM, the latched request registers and the timeout counter.

## Test plan
- sb, addr 0x8000_0003, wdata 0x1234_56AB, ready=1, resp next cycle → mem_addr 0x8000_0000, wstrb 1000, wdata 0xAB00_0000; done at cycle 3 with fault 00 and rdata 0.
- lb at 0x8000_0001 with mem_rdata 0x0000_8000 → lsu_rdata 0xFFFF_FF80. lbu at the same address → 0x0000_0080. lhu at 0x8000_0002 with rdata 0xBEEF_0000 → 0x0000_BEEF.
- lw at 0x8000_0002 → lsu_done at cycle 1, fault 01, mem_req_valid never asserted. Repeat with read=write=1 → same result.
- mem_req_ready held low 3 cycles, then high; resp_err=1 → request fields stable throughout; fault 10.
- TIMEOUT=8, no response → done after 8 counted cycles with fault 11. A response 2 cycles later is ignored, and the next lw completes normally.
- rst asserted while in WAIT → mem_req_valid and busy drop immediately, no done pulse; ex_ready=1 on the first cycle after rst falls.
